// File: rtl/ysyx_22050854_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050854_div_unit_pkg
// Brief    : Shared state encoding and latency constants for the divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22050854_div_unit_pkg;

    localparam int DIV_LAT_D = 64;
    localparam int DIV_LAT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_22050854_div_step.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050854_div_step
// Brief    : One combinational restoring-division iteration on magnitudes.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050854_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            in_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    // The shifted partial remainder can exceed XLEN bits, so the compare
    // is done one bit wider; the difference itself always fits in XLEN.
    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_diff;

    assign w_trial = {rem_in, in_bit};
    assign w_diff  = w_trial[XLEN-1:0] - divisor;
    assign q_bit   = (w_trial >= {1'b0, divisor});
    assign rem_out = q_bit ? w_diff : w_trial[XLEN-1:0];

endmodule
`default_nettype wire

// File: rtl/ysyx_22050854_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050854_div_unit
// Brief    : Iterative RV64 DIV/DIVU/REM/REMU (+W forms) with valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050854_div_unit
    import ysyx_22050854_div_unit_pkg::*;
#(
    parameter int XLEN = DIV_LAT_D,
    parameter int WLEN = DIV_LAT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic            div_signed,
    input  logic            div_word,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam int EXT_W = XLEN - WLEN;

    div_state_e       r_state;
    div_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_dsr;
    logic [XLEN-1:0]  r_res_q;
    logic [XLEN-1:0]  r_res_r;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_word;

    logic [XLEN-1:0]  w_a_ext;
    logic [XLEN-1:0]  w_b_ext;
    logic [XLEN-1:0]  w_a_mag;
    logic [XLEN-1:0]  w_b_mag;
    logic [XLEN-1:0]  w_min_neg;
    logic [XLEN-1:0]  w_spec_q;
    logic [XLEN-1:0]  w_spec_r;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_b_zero;
    logic             w_ovf;
    logic             w_special;
    logic             w_accept;
    logic             w_last;

    logic [XLEN-1:0]  w_rem_nxt;
    logic [XLEN-1:0]  w_quo_nxt;
    logic [XLEN-1:0]  w_q_signed;
    logic [XLEN-1:0]  w_r_signed;
    logic             w_q_bit;

    function automatic logic [XLEN-1:0] fit_word(input logic word, input logic [XLEN-1:0] x);
        return word ? {{EXT_W{x[WLEN-1]}}, x[WLEN-1:0]} : x;
    endfunction

    // Operand decode: extend to the active width, take magnitudes, and flag
    // the two cases that bypass the iteration entirely.
    always_comb begin
        w_a_ext = dividend;
        w_b_ext = divisor;
        if (div_word) begin
            w_a_ext = {{EXT_W{div_signed & dividend[WLEN-1]}}, dividend[WLEN-1:0]};
            w_b_ext = {{EXT_W{div_signed & divisor[WLEN-1]}},  divisor[WLEN-1:0]};
        end
        w_a_neg   = div_signed & w_a_ext[XLEN-1];
        w_b_neg   = div_signed & w_b_ext[XLEN-1];
        w_a_mag   = w_a_neg ? -w_a_ext : w_a_ext;
        w_b_mag   = w_b_neg ? -w_b_ext : w_b_ext;
        w_min_neg = div_word ? {{(EXT_W + 1){1'b1}}, {(WLEN - 1){1'b0}}}
                             : {1'b1, {(XLEN - 1){1'b0}}};
        w_b_zero  = (w_b_ext == '0);
        w_ovf     = div_signed & (w_a_ext == w_min_neg) & (&w_b_ext);
        w_special = w_b_zero | w_ovf;
        w_spec_q  = w_b_zero ? '1 : w_a_ext;
        w_spec_r  = w_b_zero ? w_a_ext : '0;
    end

    assign w_accept = div_valid & (r_state == IDLE) & ~flush;
    assign w_last   = (r_cnt == CNT_W'(1));

    ysyx_22050854_div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem_in  (r_rem),
        .in_bit  (r_quo[XLEN-1]),
        .divisor (r_dsr),
        .rem_out (w_rem_nxt),
        .q_bit   (w_q_bit)
    );

    // r_quo doubles as the dividend shift register: dividend bits leave at
    // the top while quotient bits enter at the bottom.
    assign w_quo_nxt  = {r_quo[XLEN-2:0], w_q_bit};
    assign w_q_signed = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_r_signed = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_special ? DONE : BUSY;
            BUSY:    if (w_last) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dsr   <= '0;
            r_res_q <= '0;
            r_res_r <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_word  <= 1'b0;
        end else if (flush) begin
            r_cnt   <= '0;
            r_res_q <= '0;
            r_res_r <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_word  <= div_word;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_rem   <= '0;
                        // Word operands are left-aligned so the first WLEN
                        // steps consume exactly their significant bits.
                        r_quo   <= div_word ? (w_a_mag << EXT_W) : w_a_mag;
                        r_dsr   <= w_b_mag;
                        r_cnt   <= w_special ? '0 : (div_word ? CNT_W'(WLEN) : CNT_W'(XLEN));
                        r_res_q <= w_special ? fit_word(div_word, w_spec_q) : '0;
                        r_res_r <= w_special ? fit_word(div_word, w_spec_r) : '0;
                    end
                end
                BUSY: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_res_q <= fit_word(r_word, w_q_signed);
                        r_res_r <= fit_word(r_word, w_r_signed);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_res_q <= '0;
                        r_res_r <= '0;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign div_ready = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quotient  = out_valid ? r_res_q : '0;
    assign remainder = out_valid ? r_res_r : '0;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050854_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050854_div_unit
// Brief    : Directed self-checking bench with an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050854_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        div_valid = 1'b0;
    logic        div_ready;
    logic        div_signed = 1'b0;
    logic        div_word = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int          checks = 0;
    int          failures = 0;

    logic        exp_valid = 1'b0;
    logic [63:0] exp_q = '0;
    logic [63:0] exp_r = '0;
    int          exp_lat = 0;

    typedef struct {
        logic        s;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
    } vec_t;

    ysyx_22050854_div_unit #(
        .XLEN (64),
        .WLEN (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .div_word   (div_word),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: RISC-V M-extension semantics computed with plain arithmetic.
    function automatic void model(input logic s, input logic w, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] q,
                                  output logic [63:0] r, output int lat);
        logic [31:0] a32, b32, q32, r32;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) begin
                q32 = '1; r32 = a32; lat = 1;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = '0; lat = 1;
            end else begin
                if (s) begin
                    q32 = $signed(a32) / $signed(b32);
                    r32 = $signed(a32) % $signed(b32);
                end else begin
                    q32 = a32 / b32;
                    r32 = a32 % b32;
                end
                lat = 33;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                q = '1; r = a; lat = 1;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = '0; lat = 1;
            end else begin
                if (s) begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                end else begin
                    q = a / b;
                    r = a % b;
                end
                lat = 65;
            end
        end
    endfunction

    // Every cycle: results must match the model while valid, and be zero otherwise.
    always @(negedge clk) begin
        if (out_valid) begin
            if (!exp_valid) begin
                check("cmp_spurious_valid", {63'd0, out_valid}, 64'd0);
            end else begin
                check("cmp_quotient", quotient, exp_q);
                check("cmp_remainder", remainder, exp_r);
            end
        end else begin
            check("cmp_idle_quotient", quotient, 64'd0);
            check("cmp_idle_remainder", remainder, 64'd0);
        end
    end

    task automatic issue(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b);
        int guard;
        guard = 0;
        while (!div_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_before_issue", {63'd0, div_ready}, 64'd1);
        model(s, w, a, b, exp_q, exp_r, exp_lat);
        div_valid  = 1'b1;
        div_signed = s;
        div_word   = w;
        dividend   = a;
        divisor    = b;
        exp_valid  = 1'b1;
        @(posedge clk); #1;
        div_valid  = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume(input string nm);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_valid = 1'b0;
        check({nm, "_ready_after"}, {63'd0, div_ready}, 64'd1);
    endtask

    task automatic run_op(input string nm, input logic s, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input logic use_lit,
                          input logic [63:0] lit_q, input logic [63:0] lit_r, input int lit_lat);
        int lat;
        issue(s, w, a, b);
        wait_done(lat);
        check({nm, "_lat"}, 64'(lat), 64'(exp_lat));
        check({nm, "_q"}, quotient, exp_q);
        check({nm, "_r"}, remainder, exp_r);
        if (use_lit) begin
            check({nm, "_lit_q"}, quotient, lit_q);
            check({nm, "_lit_r"}, remainder, lit_r);
            check({nm, "_lit_lat"}, 64'(lat), 64'(lit_lat));
        end
        consume(nm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[7];
        logic [63:0] hq, hr;
        int lat;

        vecs[0] = '{1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[1] = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2] = '{1'b0, 1'b1, 64'h1234_5678_8000_0001, 64'hFFFF_FFFF_0000_0000};
        vecs[3] = '{1'b1, 1'b1, 64'h0000_0000_FFFF_FFEC, 64'd3};
        vecs[4] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
        vecs[5] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9};
        vecs[6] = '{1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1};

        #12;
        check("reset_ready", {63'd0, div_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_quotient", quotient, 64'd0);
        check("reset_remainder", remainder, 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("divu_100_7", 1'b0, 1'b0, 64'd100, 64'd7, 1'b1, 64'd14, 64'd2, 65);
        run_op("div_m7_2", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("divw_ovf", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
               64'hFFFF_FFFF_8000_0000, 64'd0, 1);
        run_op("divu_by0", 1'b0, 1'b0, 64'd5, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1);
        run_op("remuw", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 1'b1,
               64'h0000_0000_5555_5553, 64'd0, 33);
        run_op("div_7_m2", 1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
        run_op("divuw_by0", 1'b0, 1'b1, 64'h1234_5678_8000_0001, 64'hFFFF_FFFF_0000_0000, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].b,
                   1'b0, 64'd0, 64'd0, 0);
        end

        // Flush on the 10th BUSY cycle.
        issue(1'b0, 1'b0, 64'd100, 64'd7);
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_valid = 1'b0;
        check("flush_ready", {63'd0, div_ready}, 64'd1);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        repeat (70) @(posedge clk);
        #1;
        check("flush_no_late_valid", {63'd0, out_valid}, 64'd0);
        run_op("after_flush", 1'b0, 1'b0, 64'd100, 64'd7, 1'b1, 64'd14, 64'd2, 65);

        // Flush beats a simultaneous request.
        div_valid = 1'b1; div_signed = 1'b0; div_word = 1'b0;
        dividend = 64'd9; divisor = 64'd0; flush = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0; flush = 1'b0;
        check("flush_vs_accept_ready", {63'd0, div_ready}, 64'd1);
        check("flush_vs_accept_valid", {63'd0, out_valid}, 64'd0);

        // Flush in DONE drops the result and overrides out_ready.
        issue(1'b0, 1'b0, 64'd9, 64'd0);
        check("done_before_flush", {63'd0, out_valid}, 64'd1);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0; exp_valid = 1'b0;
        check("flush_done_valid", {63'd0, out_valid}, 64'd0);
        check("flush_done_ready", {63'd0, div_ready}, 64'd1);

        // Results hold while the consumer stalls.
        issue(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
        wait_done(lat);
        check("hold_lat", 64'(lat), 64'd65);
        hq = quotient;
        hr = remainder;
        check("hold_lit_q", hq, 64'hFFFF_FFFF_FFFF_FFF2);
        check("hold_lit_r", hr, 64'hFFFF_FFFF_FFFF_FFFE);
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_q", quotient, hq);
            check("hold_r", remainder, hr);
        end

        // Asynchronous reset while in DONE clears outputs without a clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        exp_valid = 1'b0;
        check("rst_done_valid", {63'd0, out_valid}, 64'd0);
        check("rst_done_q", quotient, 64'd0);
        check("rst_done_r", remainder, 64'd0);
        check("rst_done_ready", {63'd0, div_ready}, 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-BUSY discards the operation.
        issue(1'b0, 1'b0, 64'd1000, 64'd3);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("busy_not_ready", {63'd0, div_ready}, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_valid = 1'b0;
        check("rst_busy_ready", {63'd0, div_ready}, 64'd1);
        check("rst_busy_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        check("rst_busy_no_valid", {63'd0, out_valid}, 64'd0);
        run_op("after_reset", 1'b0, 1'b0, 64'd1000, 64'd3, 1'b1, 64'd333, 64'd1, 65);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
